// File: rtl/ysyx_22041752_mem_arb.sv
// Two-master (fetch/data) arbiter onto a single downstream memory port with
// one outstanding transaction and a starvation guard for the fetch side.
module ysyx_22041752_mem_arb #(
    parameter int ADDR_WD    = 32,
    parameter int DATA_WD    = 64,
    parameter int STARVE_MAX = 8
) (
    input  logic                 clk,
    input  logic                 reset,

    input  logic                 inst_en,
    input  logic [ADDR_WD-1:0]   inst_addr,
    output logic                 inst_ready,
    output logic                 inst_rvalid,
    output logic [DATA_WD-1:0]   inst_rdata,

    input  logic                 data_en,
    input  logic                 data_wen,
    input  logic [ADDR_WD-1:0]   data_addr,
    input  logic [DATA_WD-1:0]   data_wdata,
    input  logic [DATA_WD/8-1:0] data_wstrb,
    output logic                 data_ready,
    output logic                 data_rvalid,
    output logic [DATA_WD-1:0]   data_rdata,

    output logic                 mem_req,
    input  logic                 mem_gnt,
    output logic                 mem_wen,
    output logic [ADDR_WD-1:0]   mem_addr,
    output logic [DATA_WD-1:0]   mem_wdata,
    output logic [DATA_WD/8-1:0] mem_wstrb,
    input  logic                 mem_rvalid,
    input  logic [DATA_WD-1:0]   mem_rdata
);

    localparam int STRB_WD = DATA_WD / 8;
    localparam int CNT_WD  = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t              state, state_nxt;
    logic [CNT_WD-1:0]   starve_cnt;
    logic                force_inst;
    logic                is_idle;
    logic                acc_inst, acc_data;
    logic                resp_done;

    logic                lat_is_data;
    logic                lat_wen;
    logic [ADDR_WD-1:0]  lat_addr;
    logic [DATA_WD-1:0]  lat_wdata;
    logic [STRB_WD-1:0]  lat_wstrb;

    assign force_inst = (starve_cnt == CNT_WD'(STARVE_MAX));
    assign is_idle    = (state == IDLE);
    assign data_ready = is_idle && !force_inst;
    assign inst_ready = is_idle && (!data_en || force_inst);
    assign acc_data   = data_en && data_ready;
    assign acc_inst   = inst_en && inst_ready;
    assign resp_done  = (state == RESP) && mem_rvalid;

    assign mem_req    = (state == REQ);
    assign mem_wen    = lat_wen;
    assign mem_addr   = lat_addr;
    assign mem_wdata  = lat_wdata;
    assign mem_wstrb  = lat_wstrb;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (acc_data || acc_inst) state_nxt = REQ;
            REQ:     if (mem_gnt)              state_nxt = RESP;
            RESP:    if (mem_rvalid)           state_nxt = IDLE;
            default:                           state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            starve_cnt  <= '0;
            lat_is_data <= 1'b0;
            lat_wen     <= 1'b0;
            lat_addr    <= '0;
            lat_wdata   <= '0;
            lat_wstrb   <= '0;
            inst_rvalid <= 1'b0;
            data_rvalid <= 1'b0;
            inst_rdata  <= '0;
            data_rdata  <= '0;
        end else begin
            state <= state_nxt;

            if (acc_data) begin
                lat_is_data <= 1'b1;
                lat_wen     <= data_wen;
                lat_addr    <= data_addr;
                lat_wdata   <= data_wdata;
                lat_wstrb   <= data_wstrb;
            end else if (acc_inst) begin
                lat_is_data <= 1'b0;
                lat_wen     <= 1'b0;
                lat_addr    <= inst_addr;
                lat_wdata   <= '0;
                lat_wstrb   <= '0;
            end

            // Counter only moves in IDLE; saturation is the force condition itself.
            if (is_idle) begin
                if (acc_inst)
                    starve_cnt <= '0;
                else if (inst_en && !force_inst)
                    starve_cnt <= starve_cnt + 1'b1;
            end

            inst_rvalid <= resp_done && !lat_is_data;
            data_rvalid <= resp_done && lat_is_data;
            if (resp_done && !lat_is_data)
                inst_rdata <= mem_rdata;
            if (resp_done && lat_is_data && !lat_wen)
                data_rdata <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_ysyx_22041752_mem_arb.sv
// Randomized bench for the fetch/data memory arbiter, checked each cycle
// against a transaction-level model of the arbitration and completion rules.
module tb_ysyx_22041752_mem_arb;

    localparam int AW = 32;
    localparam int DW = 64;
    localparam int SW = DW / 8;
    localparam int SMAX = 8;
    localparam int NCYC = 20000;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          inst_en = 1'b0;
    logic [AW-1:0] inst_addr = '0;
    logic          inst_ready, inst_rvalid;
    logic [DW-1:0] inst_rdata;
    logic          data_en = 1'b0, data_wen = 1'b0;
    logic [AW-1:0] data_addr = '0;
    logic [DW-1:0] data_wdata = '0;
    logic [SW-1:0] data_wstrb = '0;
    logic          data_ready, data_rvalid;
    logic [DW-1:0] data_rdata;
    logic          mem_req, mem_wen;
    logic          mem_gnt = 1'b0, mem_rvalid = 1'b0;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [SW-1:0] mem_wstrb;
    logic [DW-1:0] mem_rdata = '0;

    ysyx_22041752_mem_arb #(.ADDR_WD(AW), .DATA_WD(DW), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .reset(reset),
        .inst_en(inst_en), .inst_addr(inst_addr), .inst_ready(inst_ready),
        .inst_rvalid(inst_rvalid), .inst_rdata(inst_rdata),
        .data_en(data_en), .data_wen(data_wen), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_wstrb(data_wstrb), .data_ready(data_ready),
        .data_rvalid(data_rvalid), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Transaction-level model: busy/granted flags, one pending transaction,
    // a starvation tally and the architecturally visible read registers.
    bit            armed = 0;
    bit            busy = 0, granted = 0;
    int            starve = 0;
    bit            t_data, t_wen;
    logic [AW-1:0] t_addr;
    logic [DW-1:0] t_wdata;
    logic [SW-1:0] t_wstrb;
    bit            exp_ip = 0, exp_dp = 0;
    logic [DW-1:0] m_irdata = '0, m_drdata = '0;
    bit            inst_acc = 0, data_acc = 0;
    bit            want_data, want_inst;

    always @(negedge clk) begin
        inst_acc = 0;
        data_acc = 0;
        if (armed) begin
            want_data = data_en && (starve != SMAX);
            want_inst = inst_en && (!data_en || starve == SMAX);
            check_eq("data_ready", data_ready, !busy && (starve != SMAX));
            check_eq("inst_ready", inst_ready, !busy && (!data_en || starve == SMAX));
            check_eq("inst_rvalid", inst_rvalid, exp_ip);
            check_eq("data_rvalid", data_rvalid, exp_dp);
            check_eq("inst_rdata", inst_rdata, m_irdata);
            check_eq("data_rdata", data_rdata, m_drdata);
            check_eq("mem_req", mem_req, busy && !granted);
            if (busy && !granted) begin
                check_eq("mem_addr", mem_addr, t_addr);
                check_eq("mem_wen", mem_wen, t_wen);
                check_eq("mem_wstrb", mem_wstrb, t_data ? t_wstrb : '0);
                if (t_data && t_wen) check_eq("mem_wdata", mem_wdata, t_wdata);
            end
        end
        exp_ip = 0;
        exp_dp = 0;
        if (reset) begin
            armed = 1;
            busy = 0; granted = 0; starve = 0;
            m_irdata = '0; m_drdata = '0;
        end else if (busy && granted) begin
            if (mem_rvalid) begin
                busy = 0;
                if (t_data) begin
                    exp_dp = 1;
                    if (!t_wen) m_drdata = mem_rdata;
                end else begin
                    exp_ip = 1;
                    m_irdata = mem_rdata;
                end
            end
        end else if (busy) begin
            if (mem_gnt) granted = 1;
        end else begin
            if (data_en && starve != SMAX) begin
                data_acc = 1;
                t_data = 1; t_wen = data_wen; t_addr = data_addr;
                t_wdata = data_wdata; t_wstrb = data_wstrb;
                busy = 1; granted = 0;
            end else if (inst_en) begin
                inst_acc = 1;
                t_data = 0; t_wen = 0; t_addr = inst_addr;
                busy = 1; granted = 0;
            end
            if (inst_acc) starve = 0;
            else if (inst_en && starve < SMAX) starve++;
        end
    end

    function automatic bit chance(input int unsigned permille);
        return $urandom_range(999, 0) < permille;
    endfunction

    int unsigned p_inst, p_data, p_gnt, p_rv;

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        for (int unsigned cyc = 0; cyc < NCYC; cyc++) begin
            if (cyc % 1000 == 0) begin
                p_inst = $urandom_range(900, 100);
                p_data = (cyc % 3000 == 0) ? 1000 : $urandom_range(900, 50);
                p_gnt  = $urandom_range(900, 200);
                p_rv   = $urandom_range(900, 200);
            end
            @(posedge clk);
            #1;
            reset = chance(4);
            if (inst_acc || !inst_en) begin
                inst_en = chance(p_inst);
                inst_addr = {$urandom()} & 32'hFFFF_FFF8;
            end
            if (data_acc || !data_en) begin
                data_en = chance(p_data);
                data_wen = chance(400);
                data_addr = {$urandom()} & 32'hFFFF_FFF8;
                data_wdata = {$urandom(), $urandom()};
                data_wstrb = SW'($urandom());
            end
            mem_rdata = {$urandom(), $urandom()};
            mem_gnt = busy && !granted && chance(p_gnt);
            if (busy && granted) mem_rvalid = chance(p_rv);
            else if (!busy)      mem_rvalid = chance(60);
            else                 mem_rvalid = 1'b0;
        end
        @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
